// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event front-end: event codes, per-key FSM states
// and the timer sizing helper.
package key_evt_pkg;

  localparam logic [1:0] EVT_NONE   = 2'd0;
  localparam logic [1:0] EVT_SHORT  = 2'd1;
  localparam logic [1:0] EVT_DOUBLE = 2'd2;
  localparam logic [1:0] EVT_LONG   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DOWN1 = 2'd1,
    ST_UP1   = 2'd2,
    ST_HOLD  = 2'd3
  } key_state_e;

  function automatic int timer_width(input int long_ms, input int dbl_ms);
    int tmax;
    tmax = (long_ms > dbl_ms) ? long_ms : dbl_ms;
    return $clog2(tmax + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, tick-based debounce, press classifier FSM and a
// single-entry event slot drained by the top-level arbiter via grant.
module key_channel
  import key_evt_pkg::*;
#(
  parameter int DEB_MS  = 20,
  parameter int LONG_MS = 1000,
  parameter int DBL_MS  = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       tick,
  input  logic       grant,
  output logic       slot_valid,
  output logic [1:0] slot_type,
  output logic       key_level,
  output logic       drop
);

  localparam int TMAX = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
  localparam int TW   = timer_width(LONG_MS, DBL_MS);
  localparam int DW   = $clog2(DEB_MS + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  key_state_e    state_q, state_d;
  logic          slot_valid_q, slot_valid_d;
  logic [1:0]    slot_type_q, slot_type_d;
  logic          drop_q, drop_d;
  logic          press_stb, rel_stb, emit;
  logic [1:0]    emit_type;

  // The counter value is compared registered, so a new level must survive one
  // cycle past the DEB_MS-th tick; short glitches straddling two ticks are rejected.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DW'(DEB_MS)) begin
      level_d   = sync2_q;
      deb_cnt_d = '0;
    end else if (tick) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
    press_stb = level_q & ~level_d;
    rel_stb   = ~level_q & level_d;
  end

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_type = EVT_NONE;
    case (state_q)
      ST_IDLE: if (press_stb) state_d = ST_DOWN1;
      ST_DOWN1: begin
        // A release landing on the LONG timeout returns to IDLE so it is not lost in HOLD.
        if (timer_q == TW'(LONG_MS)) begin
          emit      = 1'b1;
          emit_type = EVT_LONG;
          state_d   = rel_stb ? ST_IDLE : ST_HOLD;
        end else if (rel_stb) begin
          state_d = ST_UP1;
        end
      end
      ST_UP1: begin
        if (press_stb) begin
          emit      = 1'b1;
          emit_type = EVT_DOUBLE;
          state_d   = ST_HOLD;
        end else if (timer_q == TW'(DBL_MS)) begin
          emit      = 1'b1;
          emit_type = EVT_SHORT;
          state_d   = ST_IDLE;
        end
      end
      ST_HOLD: if (rel_stb) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (tick && (timer_q != TW'(TMAX))) timer_d = timer_q + TW'(1);
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_type_d  = slot_type_q;
    drop_d       = 1'b0;
    if (grant) slot_valid_d = 1'b0;
    if (emit) begin
      if (slot_valid_q && !grant) begin
        drop_d = 1'b1;
      end else begin
        slot_valid_d = 1'b1;
        slot_type_d  = emit_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      deb_cnt_q    <= '0;
      timer_q      <= '0;
      state_q      <= ST_IDLE;
      slot_valid_q <= 1'b0;
      slot_type_q  <= EVT_NONE;
      drop_q       <= 1'b0;
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      deb_cnt_q    <= deb_cnt_d;
      timer_q      <= timer_d;
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_type_q  <= slot_type_d;
      drop_q       <= drop_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_type  = slot_type_q;
  assign key_level  = level_q;
  assign drop       = drop_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key front-end: shared tick prescaler, N key channels and a round-robin
// arbiter feeding one registered valid/ready event stream.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int TICK_CYCLES = 50_000,
  parameter int DEB_MS      = 20,
  parameter int LONG_MS     = 1000,
  parameter int DBL_MS      = 300,
  localparam int KW         = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KW-1:0]     evt_key,
  output logic [1:0]        evt_type,
  output logic              evt_drop
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  // Handshake: an event transfers on a clock edge where evt_valid && evt_ready;
  // while evt_valid && !evt_ready the key/type registers hold their value.

  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick;
  logic [N_KEYS-1:0]      slot_valid, grant, drop;
  logic [N_KEYS-1:0][1:0] slot_type;
  logic [KW-1:0]          rr_q, rr_d, gnt_idx, cand;
  logic                   found, load;
  logic                   evt_valid_q, evt_valid_d;
  logic [KW-1:0]          evt_key_q, evt_key_d;
  logic [1:0]             evt_type_q, evt_type_d;

  assign tick    = (presc_q == PW'(TICK_CYCLES - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_channel #(
      .DEB_MS (DEB_MS),
      .LONG_MS(LONG_MS),
      .DBL_MS (DBL_MS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in[g]),
      .tick      (tick),
      .grant     (grant[g]),
      .slot_valid(slot_valid[g]),
      .slot_type (slot_type[g]),
      .key_level (key_level[g]),
      .drop      (drop[g])
    );
  end

  assign evt_drop = |drop;
  assign load     = !evt_valid_q || evt_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    grant   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cand = KW'((int'(rr_q) + i) % N_KEYS);
      if (!found && slot_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (load && found) grant[gnt_idx] = 1'b1;

    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    if (load) begin
      evt_valid_d = found;
      evt_key_d   = found ? gnt_idx : '0;
      evt_type_d  = found ? slot_type[gnt_idx] : EVT_NONE;
      if (found) rr_d = (int'(gnt_idx) == N_KEYS - 1) ? '0 : gnt_idx + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= EVT_NONE;
    end else begin
      presc_q     <= presc_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a fast tick: SHORT/DOUBLE/LONG
// classification, glitch rejection, round-robin under backpressure, drop and reset.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic       evt_ready = 1'b1;
  logic [3:0] key_level;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_drop;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int lvl3_low_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         obs_cyc_q[$];

  key_event_ctrl #(
    .N_KEYS     (4),
    .TICK_CYCLES(4),
    .DEB_MS     (2),
    .LONG_MS    (20),
    .DBL_MS     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_level(key_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .evt_drop (evt_drop)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: accepted events, drop pulses, key3 level
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      obs_q.push_back({evt_key, evt_type});
      obs_cyc_q.push_back(cyc);
    end
    if (evt_drop) drop_cnt++;
    if (!key_level[3]) lvl3_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_in = 4'hF;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic tap(input logic [3:0] low_mask, input int low_cycles, input int after);
    key_in = ~low_mask;
    wait_cycles(low_cycles);
    key_in = 4'hF;
    wait_cycles(after);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_evt"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    int d0, l0, c_edge, lat;

    wait_cycles(3);
    check("rst_level", key_level, 4'hF);
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_type", evt_type, 0);
    check("rst_drop", evt_drop, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: key1 SHORT, debounce latency window
    d0 = drop_cnt;
    key_in[1] = 1'b0;
    wait_cycles(5);
    check("s1_level_early", key_level[1], 1);
    wait_cycles(9);
    check("s1_level_late", key_level[1], 0);
    wait_cycles(26);
    key_in[1] = 1'b1;
    wait_cycles(100);
    exp_q.push_back({2'd1, 2'd1});
    check_events("s1");
    check("s1_drop", drop_cnt - d0, 0);

    // 2: key0 DOUBLE
    key_in[0] = 1'b0;
    wait_cycles(30);
    key_in[0] = 1'b1;
    wait_cycles(12);
    key_in[0] = 1'b0;
    wait_cycles(30);
    key_in[0] = 1'b1;
    wait_cycles(100);
    exp_q.push_back({2'd0, 2'd2});
    check_events("s2");

    // 3: key2 LONG, then silent release
    key_in[2] = 1'b0;
    c_edge = cyc;
    wait_cycles(120);
    key_in[2] = 1'b1;
    wait_cycles(100);
    if (obs_cyc_q.size() > 0) begin
      lat = obs_cyc_q[0] - c_edge;
      check("s3_long_latency_ok", (lat >= 80 && lat <= 100), 1);
    end
    exp_q.push_back({2'd2, 2'd3});
    check_events("s3");

    // 4: glitches on key3
    l0 = lvl3_low_cnt;
    for (int i = 0; i < 4; i++) begin
      key_in[3] = 1'b0;
      wait_cycles(5);
      key_in[3] = 1'b1;
      wait_cycles(10);
    end
    wait_cycles(60);
    check("s4_level3_low_cycles", lvl3_low_cnt - l0, 0);
    check_events("s4");

    // 5: simultaneous SHORTs under backpressure, round-robin from pointer 0
    do_reset();
    evt_ready = 1'b0;
    tap(4'b1011, 40, 80);
    for (int i = 0; i < 4; i++) begin
      check("s5_stall_valid", evt_valid, 1);
      check("s5_stall_key", evt_key, 0);
      check("s5_stall_type", evt_type, 1);
      wait_cycles(3);
    end
    evt_ready = 1'b1;
    wait_cycles(10);
    exp_q.push_back({2'd0, 2'd1});
    exp_q.push_back({2'd1, 2'd1});
    exp_q.push_back({2'd3, 2'd1});
    check_events("s5");

    // 6: output + slot full, third SHORT dropped; then reset mid-DOWN1
    do_reset();
    evt_ready = 1'b0;
    d0 = drop_cnt;
    tap(4'b0001, 40, 80);
    tap(4'b0001, 40, 80);
    check("s6_drop_before", drop_cnt - d0, 0);
    tap(4'b0001, 40, 80);
    check("s6_drop_pulse", drop_cnt - d0, 1);
    evt_ready = 1'b1;
    wait_cycles(10);
    exp_q.push_back({2'd0, 2'd1});
    exp_q.push_back({2'd0, 2'd1});
    check_events("s6");

    evt_ready = 1'b0;
    tap(4'b0010, 40, 80);
    key_in[2] = 1'b0;
    wait_cycles(20);
    check("s6_pre_level", key_level, 4'b1011);
    check("s6_pre_valid", evt_valid, 1);
    check("s6_pre_key", evt_key, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_level", key_level, 4'hF);
    check("s6_rst_valid", evt_valid, 0);
    check("s6_rst_key", evt_key, 0);
    check("s6_rst_type", evt_type, 0);
    check("s6_rst_drop", evt_drop, 0);
    key_in = 4'hF;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
